// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and widths for the two-channel TDM demultiplexer
package tdm_pkg;
    typedef enum logic [1:0] {SEEK, EXPECT1, EXPECT0} state_t;
    localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/tdm_demux2_if.sv
// tdm_demux2_if: TDM bus input and parallel channel outputs of the demultiplexer
interface tdm_demux2_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_sync;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic             out_valid;
    logic             locked;
    logic             sync_err;
    logic [15:0]      frame_count;
    modport master (output in_data, in_valid, in_sync,
                    input out0, out1, out_valid, locked, sync_err, frame_count);
    modport slave (input in_data, in_valid, in_sync,
                   output out0, out1, out_valid, locked, sync_err, frame_count);
endinterface

// File: rtl/tdm_frame_counter.sv
// tdm_frame_counter: wrapping count of completed frames
module tdm_frame_counter
    import tdm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic [FRAME_CNT_W-1:0] count
);
    always_ff @(posedge clk)
        count <= rst ? '0 : count + FRAME_CNT_W'(en);
endmodule

// File: rtl/tdm_demux2.sv
// tdm_demux2: tracks sync alignment on a two-channel TDM bus and emits whole frames
module tdm_demux2
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         reset,
    tdm_demux2_if.slave bus
);
    state_t           state;
    logic [WIDTH-1:0] stage0;
    logic             frame_done;
    logic             proto_err;
    assign frame_done = bus.in_valid && !bus.in_sync && state == EXPECT1;
    assign proto_err  = bus.in_valid && (bus.in_sync ? state == EXPECT1 : state == EXPECT0);
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SEEK;
            stage0        <= '0;
            bus.out0      <= '0;
            bus.out1      <= '0;
            bus.out_valid <= 1'b0;
            bus.locked    <= 1'b0;
            bus.sync_err  <= 1'b0;
        end else begin
            bus.out_valid <= frame_done;
            bus.sync_err  <= proto_err;
            if (bus.in_valid) begin
                if (bus.in_sync) begin
                    // a sync always restarts a frame; alignment survives only if it follows a full frame
                    stage0     <= bus.in_data;
                    state      <= EXPECT1;
                    bus.locked <= state == EXPECT0;
                end else if (state == EXPECT1) begin
                    bus.out0   <= stage0;
                    bus.out1   <= bus.in_data;
                    state      <= EXPECT0;
                    bus.locked <= 1'b1;
                end else begin
                    state      <= SEEK;
                    bus.locked <= 1'b0;
                end
            end
        end
    end
    tdm_frame_counter u_cnt (
        .clk  (clk),
        .rst  (reset),
        .en   (frame_done),
        .count(bus.frame_count)
    );
endmodule
